// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher: one inverse round per clock. The NR+1 round
// keys arrive pre-expanded on ExpandedKeys, with round 0 at the MSBs.
module aes_inv_cipher #(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [127:0]          in_bytes,
  input  logic [128*(NR+1)-1:0] ExpandedKeys,
  output logic [127:0]          out,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} fsm_t;

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  fsm_t         fsm_reg;
  logic [127:0] state_reg;
  logic [127:0] out_reg;
  logic [3:0]   rnd_reg;
  logic         busy_reg;
  logic         done_reg;

  logic [127:0] round_key [16];
  logic [127:0] sub_bytes;
  logic [127:0] add_key;
  logic [127:0] mix_cols;

  // Entry 0 sits at the MSBs, so byte b lives at bits [8*(255-b)+7 -: 8].
  function automatic logic [7:0] inv_sub(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  if (NK != NR - 6) begin : g_bad_cfg
    $error("aes_inv_cipher: NK and NR do not describe an AES variant");
  end

  // Slots above NR are tied off so rnd can index the table at full width.
  for (genvar gi = 0; gi < 16; gi++) begin : g_key
    if (gi <= NR) begin : g_used
      assign round_key[gi] = ExpandedKeys[128*(NR+1)-1-128*gi -: 128];
    end else begin : g_unused
      assign round_key[gi] = '0;
    end
  end

  // InvShiftRows is pure wiring: row r of column c comes from column c-r.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int SRC = 4 * ((gi / 4 - gi % 4 + 4) % 4) + gi % 4;
    assign sub_bytes[127-8*gi -: 8] = inv_sub(state_reg[127-8*SRC -: 8]);
  end

  assign add_key = sub_bytes ^ round_key[rnd_reg];

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = add_key[127-32*gi -: 32];
    assign mix_cols[127-32*gi -: 32] = {
      gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
      gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
      gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
      gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)
    };
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg   <= S_IDLE;
      state_reg <= '0;
      out_reg   <= '0;
      rnd_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (fsm_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= in_bytes ^ round_key[NR];
            rnd_reg   <= 4'(NR - 1);
            busy_reg  <= 1'b1;
            fsm_reg   <= S_ROUND;
          end
        end
        S_ROUND: begin
          state_reg <= mix_cols;
          rnd_reg   <= rnd_reg - 4'd1;
          if (rnd_reg == 4'd1) fsm_reg <= S_FINAL;
        end
        S_FINAL: begin
          // rnd is 0 here, so add_key already carries round key 0.
          out_reg  <= add_key;
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
          fsm_reg  <= S_IDLE;
        end
        default: fsm_reg <= S_IDLE;
      endcase
    end
  end

  assign out  = out_reg;
  assign busy = busy_reg;
  assign done = done_reg;
endmodule
